data_ram: RTL

Synchronous data-memory responder at the far end of the MEM-stage data bus. It accepts the MEM stage's chip-enable/write-enable/address/byte-select/data request and performs big-endian byte-lane reads and writes on a 2**ADDR_W-word array. It inserts a programmable number of wait states and holds the pipeline with a stall request until the access completes. Read data is registered and returned to the MEM stage's load-data input.

---
 rtl/data_ram_if.sv | 21 ++
 rtl/data_ram.sv | 132 +++++++++++++
 2 files changed

// File: rtl/data_ram_if.sv
// data_ram_if: MEM-stage data bus between the pipeline (master) and data_ram (slave).
interface data_ram_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  modport master (
    output ce, we, addr, sel, wdata,
    input  rdata, stall, err
  );

  modport slave (
    input  ce, we, addr, sel, wdata,
    output rdata, stall, err
  );
endinterface

// File: rtl/data_ram.sv
// data_ram: MEM-stage data memory responder with big-endian byte lanes,
// programmable wait states and a stall request that holds the pipeline.
// Optional feature: define DATA_RAM_ALIGN_CHECK_EN to reject illegal
// (sel, addr[1:0]) pairs with a one-cycle err_o pulse instead of an access.
module data_ram #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input logic       clk,
  input logic       rst,
  data_ram_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_idx;
  logic [3:0]          lat_sel;
  logic [31:0]         lat_wdata;
  logic [31:0]         rdata_q;
  logic [31:0]         mem [2**ADDR_W];
  logic                req_bad;
  logic                access;
  logic                unused_addr;

  // Upper address bits wrap away; the low two only matter for the alignment check.
  assign unused_addr = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

`ifdef DATA_RAM_ALIGN_CHECK_EN
  logic err_q;

  // Classify the incoming request: only naturally aligned lane/offset pairs are legal.
  always_comb begin
    req_bad = 1'b1;
    case ({bus.sel, bus.addr[1:0]})
      6'b1111_00, 6'b1100_00, 6'b0011_10,
      6'b1000_00, 6'b0100_01, 6'b0010_10, 6'b0001_11: req_bad = 1'b0;
      default:                                        req_bad = 1'b1;
    endcase
  end

  // Error pulse lands in the DONE cycle that follows a rejected request.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state == IDLE) && bus.ce && req_bad;
  end

  assign bus.err = err_q;
`else
  assign req_bad = 1'b0;
  assign bus.err = 1'b0;
`endif

  // Next-state logic; access marks the edge where the array is read or written.
  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ce) state_nxt = req_bad ? DONE : BUSY;
      end
      BUSY: begin
        if (!bus.ce) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The stall is raised combinationally on a new request so the pipeline holds immediately.
  assign bus.stall = ((state == IDLE) && bus.ce) || (state == BUSY);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request capture, wait-state countdown and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      rdata_q   <= 32'h0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_sel   <= 4'h0;
      lat_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ce) begin
            if (req_bad) begin
              rdata_q <= 32'h0;
            end else begin
              lat_we    <= bus.we;
              lat_idx   <= bus.addr[ADDR_W+1:2];
              lat_sel   <= bus.sel;
              lat_wdata <= bus.wdata;
              cnt       <= WAIT_INIT;
            end
          end
        end
        BUSY: begin
          if (bus.ce && (cnt != 4'd0)) cnt <= cnt - 4'd1;
          if (access && !lat_we)      rdata_q <= mem[lat_idx];
        end
        default: ;
      endcase
    end
  end

  // Byte-lane write; lane i covers bits 8i+7:8i, so sel[3] is the big-endian byte 0.
  always_ff @(posedge clk) begin
    if (!rst && access && lat_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_sel[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

  assign bus.rdata = rdata_q;

endmodule
